// File: rtl/enc_pkg.sv
// enc_pkg: shared types and helpers for the streaming SECDED encoder.
//   cw_mode_t  - per-word codeword width selector (8/16/32/64 bits)
//   cw_n/k/r   - codeword bits, data bits and Hamming check bits for a mode
//   MAX_PARITY - widest parity field (R+1 for the 64-bit mode)
package enc_pkg;

  typedef enum logic [1:0] {
    CW_8  = 2'b00,
    CW_16 = 2'b01,
    CW_32 = 2'b10,
    CW_64 = 2'b11
  } cw_mode_t;

  localparam int MAX_PARITY = 7;

  function automatic int cw_n(input cw_mode_t mode);
    case (mode)
      CW_8:    return 8;
      CW_16:   return 16;
      CW_32:   return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cw_k(input cw_mode_t mode);
    case (mode)
      CW_8:    return 4;
      CW_16:   return 11;
      CW_32:   return 26;
      default: return 57;
    endcase
  endfunction

  function automatic int cw_r(input cw_mode_t mode);
    case (mode)
      CW_8:    return 3;
      CW_16:   return 4;
      CW_32:   return 5;
      default: return 6;
    endcase
  endfunction

endpackage

// File: rtl/enc_parity_gen.sv
// enc_parity_gen: combinational extended-Hamming parity generator.
//   R       - number of Hamming check bits; K = 2^R - R - 1 data bits
//   data    - K data bits, data[j] sits at the j-th non-power-of-two position
//   parity  - {overall parity, c_{R-1} .. c_0}
module enc_parity_gen #(
  parameter int R = 3,
  localparam int K = (1 << R) - R - 1
) (
  input  logic [K-1:0] data,
  output logic [R:0]   parity
);

  // Builds, at elaboration time, the set of data bits whose Hamming
  // position has bit 'bit_idx' set. Data bits fill positions 3,5,6,7,9,...
  function automatic logic [K-1:0] check_mask(input int bit_idx);
    logic [K-1:0] m;
    int j;
    m = '0;
    j = 0;
    for (int pos = 1; pos < (1 << R); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> bit_idx) & 1) != 0) m[j] = 1'b1;
        j++;
      end
    end
    return m;
  endfunction

  // Each check bit is a fixed XOR tree over its masked data bits.
  for (genvar i = 0; i < R; i++) begin : g_check
    localparam logic [K-1:0] CMASK = check_mask(i);
    assign parity[i] = ^(data & CMASK);
  end

  // Overall parity covers the data and every Hamming check bit.
  assign parity[R] = ^{data, parity[R-1:0]};

endmodule

// File: rtl/enc_stream_secded.sv
// enc_stream_secded: two-stage streaming SECDED encoder with valid/ready.
//   clk, rst        - clock, synchronous active-low reset
//   in_valid/ready  - input handshake; codeword_width, data_in, inject_mask
//                     are captured together on acceptance
//   out_valid/ready - output handshake for data_out and cw_err
//   data_out        - codeword ^ mask, zero above N bits; 0 for illegal mode
//   cw_err          - the word used a mode these parameters cannot encode
//   word_cnt        - saturating count of delivered codewords
module enc_stream_secded
  import enc_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            codeword_width,
  input  logic [AMBA_WORD-1:0]  data_in,
  input  logic [DATA_WIDTH-1:0] inject_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  cw_err,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam bit MODE64_OK = (AMBA_WORD >= 57) && (DATA_WIDTH >= 64);
  localparam int KMAX      = 57;
  localparam int CW_W      = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;

  logic                  s1_valid;
  logic [KMAX-1:0]       s1_data;
  cw_mode_t              s1_mode;
  logic [DATA_WIDTH-1:0] s1_mask;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic                  s2_err;

  logic                  s1_advance;
  logic                  in_hs;
  logic                  out_hs;

  logic [3:0]            par8;
  logic [4:0]            par16;
  logic [5:0]            par32;
  logic [MAX_PARITY-1:0] par64;

  logic [CW_W-1:0]       cw_raw;
  logic [CW_W-1:0]       keep_mask;
  logic [CW_W-1:0]       cw_final;
  logic                  cw_illegal;

  // S1 may move into S2 whenever S2 is empty or is draining this cycle.
  // in_ready depends only on stage state, out_ready and reset, never on
  // in_valid, and is held low while reset is asserted.
  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = rst & (~s1_valid | s1_advance);
  assign in_hs      = in_valid & in_ready;
  assign out_hs     = s2_valid & out_ready;

  assign out_valid  = s2_valid;
  assign data_out   = s2_data;
  assign cw_err     = s2_err;

  // One parity generator per mode, all fed from the S1 payload.
  enc_parity_gen #(.R(3)) u_par8  (.data(s1_data[3:0]),  .parity(par8));
  enc_parity_gen #(.R(4)) u_par16 (.data(s1_data[10:0]), .parity(par16));
  enc_parity_gen #(.R(5)) u_par32 (.data(s1_data[25:0]), .parity(par32));

  // The 64-bit generator exists only when the buses can carry that mode;
  // otherwise such words are flagged illegal and the parity is never used.
  if (MODE64_OK) begin : g_par64
    enc_parity_gen #(.R(6)) u_par64 (.data(s1_data[56:0]), .parity(par64));
  end else begin : g_no_par64
    assign par64 = '0;
  end

  // Assemble the codeword for the S1 mode with the parity field in the
  // LSBs, apply the injection mask, then clear everything at and above N.
  always_comb begin
    cw_raw = '0;
    case (s1_mode)
      CW_8:    cw_raw[7:0]  = {s1_data[3:0],  par8};
      CW_16:   cw_raw[15:0] = {s1_data[10:0], par16};
      CW_32:   cw_raw[31:0] = {s1_data[25:0], par32};
      default: cw_raw[63:0] = {s1_data[56:0], par64};
    endcase
    keep_mask  = (CW_W'(1) << cw_n(s1_mode)) - CW_W'(1);
    cw_illegal = (s1_mode == CW_64) && !MODE64_OK;
    cw_final   = cw_illegal ? '0 : ((cw_raw ^ CW_W'(s1_mask)) & keep_mask);
  end

  // Stage 1 loads whenever it can accept; a cycle without in_valid in
  // that situation empties it. It otherwise holds while S2 is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= CW_8;
      s1_mask  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_hs) begin
        s1_data <= KMAX'(data_in);
        s1_mode <= cw_mode_t'(codeword_width);
        s1_mask <= inject_mask;
      end
    end
  end

  // Stage 2 takes the finished codeword from S1 when it is free to move,
  // and holds data_out/cw_err stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= DATA_WIDTH'(cw_final);
        s2_err  <= cw_illegal;
      end
    end
  end

  // Delivered-word counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (out_hs && (word_cnt != {CNT_WIDTH{1'b1}})) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_enc_stream_secded.sv
// tb_enc_stream_secded: directed, table-driven bench for enc_stream_secded.
// Main instance uses default parameters; a second instance
// (64-bit buses, 2-bit counter) covers the 64-bit mode and saturation.
module tb_enc_stream_secded;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  codeword_width;
  logic [31:0] data_in;
  logic [31:0] inject_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        cw_err;
  logic [15:0] word_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [1:0]  s_codeword_width;
  logic [63:0] s_data_in;
  logic [63:0] s_inject_mask;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [63:0] s_data_out;
  logic        s_cw_err;
  logic [1:0]  s_word_cnt;

  int total;
  int bad;
  int exp_cnt;

  enc_stream_secded dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .codeword_width(codeword_width), .data_in(data_in),
    .inject_mask(inject_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .cw_err(cw_err), .word_cnt(word_cnt)
  );

  enc_stream_secded #(.AMBA_WORD(64), .DATA_WIDTH(64), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .codeword_width(s_codeword_width), .data_in(s_data_in),
    .inject_mask(s_inject_mask),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .data_out(s_data_out), .cw_err(s_cw_err), .word_cnt(s_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  // Independent reference: syndrome-style Hamming encode. Returns {err, cw}.
  function automatic logic [64:0] ref_encode(input logic [1:0] mode,
                                             input logic [63:0] data,
                                             input logic [63:0] mask,
                                             input bit ok64);
    int n, k, r, j, synd;
    logic dpar;
    logic [63:0] cw, keep, checks;
    case (mode)
      2'b00:   begin n = 8;  k = 4;  r = 3; end
      2'b01:   begin n = 16; k = 11; r = 4; end
      2'b10:   begin n = 32; k = 26; r = 5; end
      default: begin n = 64; k = 57; r = 6; end
    endcase
    if (mode == 2'b11 && !ok64) return {1'b1, 64'h0};
    synd = 0;
    dpar = 1'b0;
    j = 0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (data[j]) begin
          synd = synd ^ pos;
          dpar = ~dpar;
        end
        j++;
      end
    end
    checks = 64'(synd);
    cw = '0;
    for (int b = 0; b < r; b++) cw[b] = checks[b];
    cw[r] = dpar ^ (^checks);
    for (int b = 0; b < k; b++) cw[r + 1 + b] = data[b];
    keep = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    return {1'b0, (cw ^ mask) & keep};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] mode,
                                input logic [31:0] data, input logic [31:0] mask);
    in_valid       = v;
    codeword_width = mode;
    data_in        = data;
    inject_mask    = mask;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
    s_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  logic [1:0]  b2b_mode[4];
  logic [31:0] b2b_data[4];
  logic [31:0] b2b_exp[4];
  logic [31:0] bp_data[3];
  logic [31:0] hold;
  logic [63:0] s_data[5];
  logic [63:0] s_mask[5];
  logic [64:0] r65;
  int n_out, first_cyc, accepted, stale, s_hs, s_n;

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
    s_in_valid = 1'b0;
    s_codeword_width = 2'b11;
    s_data_in = '0;
    s_inject_mask = '0;
    s_out_ready = 1'b1;

    vecs[0]  = '{2'b00, 32'h0000000B, 32'h00000000, 32'h000000B1, 1'b0};
    vecs[1]  = '{2'b01, 32'h000007FF, 32'h00000000, 32'h0000FFFF, 1'b0};
    vecs[2]  = '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[3]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00000000, 1'b1};
    vecs[4]  = '{2'b00, 32'h0000000B, 32'h00000001, 32'h000000B0, 1'b0};
    vecs[5]  = '{2'b00, 32'h0000000B, 32'hFFFFFF00, 32'h000000B1, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0};
    vecs[7]  = '{2'b10, 32'h03FFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{2'b00, 32'h00000001, 32'h00000000, 32'h0000001B, 1'b0};
    vecs[9]  = '{2'b00, 32'h0000FFF0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{2'b00, 32'h0000000F, 32'h00000000, 32'h000000FF, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_output("rst out_valid", 64'(out_valid), 64'd0);
    check_output("rst data_out", 64'(data_out), 64'd0);
    check_output("rst cw_err", 64'(cw_err), 64'd0);
    check_output("rst word_cnt", 64'(word_cnt), 64'd0);
    check_output("rst in_ready", 64'(in_ready), 64'd0);
    check_output("rst sat word_cnt", 64'(s_word_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("release in_ready", 64'(in_ready), 64'd1);

    // Single words from the table, latency checked at t+1 and t+2
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply_stimulus(1'b1, vecs[i].mode, vecs[i].data, vecs[i].mask);
      #1;
      check_output($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      check_output($sformatf("vec%0d early valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      check_output($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      check_output($sformatf("vec%0d data_out", i), 64'(data_out), 64'(vecs[i].exp_data));
      check_output($sformatf("vec%0d cw_err", i), 64'(cw_err), 64'(vecs[i].exp_err));
      exp_cnt++;
      @(negedge clk);
      #1;
      check_output($sformatf("vec%0d word_cnt", i), 64'(word_cnt), 64'(exp_cnt));
      check_output($sformatf("vec%0d no repeat", i), 64'(out_valid), 64'd0);
    end

    // Back-to-back words with mode changes, one per cycle
    do_reset();
    b2b_mode[0] = 2'b00; b2b_data[0] = 32'h00000005;
    b2b_mode[1] = 2'b01; b2b_data[1] = 32'h000002AA;
    b2b_mode[2] = 2'b10; b2b_data[2] = 32'h0155AAAA;
    b2b_mode[3] = 2'b00; b2b_data[3] = 32'h0000000E;
    for (int i = 0; i < 4; i++) begin
      r65 = ref_encode(b2b_mode[i], 64'(b2b_data[i]), 64'h0, 1'b0);
      b2b_exp[i] = r65[31:0];
    end
    n_out = 0;
    first_cyc = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 4) apply_stimulus(1'b1, b2b_mode[cyc], b2b_data[cyc], 32'h0);
      else apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      if (cyc < 4) check_output($sformatf("b2b in_ready c%0d", cyc), 64'(in_ready), 64'd1);
      if (out_valid) begin
        if (n_out < 4) begin
          check_output($sformatf("b2b data w%0d", n_out), 64'(data_out), 64'(b2b_exp[n_out]));
          check_output($sformatf("b2b cycle w%0d", n_out), 64'(cyc), 64'(n_out + 2));
        end else begin
          check_output("b2b extra word", 64'd1, 64'd0);
        end
        n_out++;
      end
    end
    check_output("b2b word count", 64'(n_out), 64'd4);
    check_output("b2b word_cnt", 64'(word_cnt), 64'd4);

    // Backpressure: out_ready low for five cycles, in_valid held
    bp_data[0] = 32'h3; bp_data[1] = 32'h6; bp_data[2] = 32'h9;
    accepted = 0;
    hold = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      apply_stimulus(1'b1, 2'b00, bp_data[accepted], 32'h0);
      #1;
      check_output($sformatf("bp in_ready c%0d", cyc), 64'(in_ready), (cyc < 2) ? 64'd1 : 64'd0);
      if (in_ready) accepted++;
      if (cyc >= 2) begin
        check_output($sformatf("bp out_valid c%0d", cyc), 64'(out_valid), 64'd1);
        if (cyc == 2) hold = data_out;
        else check_output($sformatf("bp stable c%0d", cyc), 64'(data_out), 64'(hold));
      end
    end
    check_output("bp accepted", 64'(accepted), 64'd2);
    n_out = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      if (out_valid) begin
        r65 = ref_encode(2'b00, 64'(bp_data[(n_out < 2) ? n_out : 0]), 64'h0, 1'b0);
        if (n_out < 2) check_output($sformatf("bp drain w%0d", n_out), 64'(data_out), 64'(r65[31:0]));
        else check_output("bp extra word", 64'd1, 64'd0);
        n_out++;
      end
    end
    check_output("bp drained", 64'(n_out), 64'd2);
    check_output("bp word_cnt", 64'(word_cnt), 64'd6);

    // Reset with two words in flight
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      apply_stimulus(1'b1, 2'b00, 32'h5 + 32'(cyc), 32'h0);
    end
    @(negedge clk);
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check_output("mid rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    check_output("mid rst out_valid", 64'(out_valid), 64'd0);
    check_output("mid rst word_cnt", 64'(word_cnt), 64'd0);
    check_output("mid rst data_out", 64'(data_out), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    check_output("mid rst stale words", 64'(stale), 64'd0);

    // 64-bit mode and counter saturation on the wide instance
    s_data[0] = 64'h01FF_FFFF_FFFF_FFFF; s_mask[0] = 64'h0;
    s_data[1] = 64'h0;                   s_mask[1] = 64'h0;
    s_data[2] = 64'h1;                   s_mask[2] = 64'h0;
    s_data[3] = 64'h0123_4567_89AB_CDEF; s_mask[3] = 64'h0;
    s_data[4] = 64'hFFFF_FFFF_FFFF_FFFF; s_mask[4] = 64'h8000_0000_0000_0001;
    s_hs = 0;
    s_n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      s_in_valid = (cyc < 5);
      s_codeword_width = 2'b11;
      s_data_in = s_data[(cyc < 5) ? cyc : 0];
      s_inject_mask = s_mask[(cyc < 5) ? cyc : 0];
      #1;
      check_output($sformatf("sat word_cnt c%0d", cyc), 64'(s_word_cnt),
                   (s_hs < 3) ? 64'(s_hs) : 64'd3);
      if (s_out_valid) begin
        if (s_n < 5) begin
          r65 = ref_encode(2'b11, s_data[s_n], s_mask[s_n], 1'b1);
          check_output($sformatf("sat data w%0d", s_n), s_data_out, r65[63:0]);
          check_output($sformatf("sat cw_err w%0d", s_n), 64'(s_cw_err), 64'd0);
        end else begin
          check_output("sat extra word", 64'd1, 64'd0);
        end
        s_n++;
        s_hs++;
      end
    end
    check_output("sat words out", 64'(s_n), 64'd5);
    check_output("sat final word_cnt", 64'(s_word_cnt), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
